// File: rtl/multi_edge_detector.sv
// N-channel edge detector: per channel a synchroniser, a debounce filter, mode-selectable
// edge detection with a registered one-cycle pulse, and a saturating edge counter.
module multi_edge_detector #(
    parameter int unsigned CH    = 4,
    parameter int unsigned SYNC  = 2,
    parameter int unsigned DEB   = 3,
    parameter int unsigned CNT_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic [CH-1:0]       din,
    input  logic [2*CH-1:0]     mode,
    input  logic [CH-1:0]       cnt_clr,
    output logic [CH-1:0]       level,
    output logic [CH-1:0]       pulse,
    output logic [CH*CNT_W-1:0] cnt,
    output logic                any_edge
);

    localparam int unsigned DW = (DEB > 1) ? $clog2(DEB) : 1;
    localparam logic [DW-1:0] DebMax = DW'(DEB - 1);

    for (genvar i = 0; i < int'(CH); i++) begin : g_ch
        logic [SYNC-1:0]  sync_q, sync_d;
        logic [DW-1:0]    dcnt_q, dcnt_d;
        logic             level_q, level_d;
        logic             pulse_q, pulse_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             s;
        logic             accept;

        always_comb begin
            // Shift register: stage 0 captures din, the top stage is the synchronised value.
            sync_d  = (sync_q << 1) | SYNC'(din[i]);
            s       = sync_q[SYNC-1];
            accept  = 1'b0;
            dcnt_d  = dcnt_q;
            level_d = level_q;
            if (s == level_q) begin
                dcnt_d = '0;
            end else if (dcnt_q == DebMax) begin
                accept  = 1'b1;
                level_d = s;
                dcnt_d  = '0;
            end else begin
                dcnt_d = dcnt_q + 1'b1;
            end

            // On acceptance s is the new level, so s=1 means rise and s=0 means fall.
            pulse_d = enable & accept & ((s & mode[2*i]) | (~s & mode[2*i+1]));

            cnt_d = cnt_q;
            if (cnt_clr[i]) begin
                cnt_d = '0;
            end else if (pulse_d && (cnt_q != '1)) begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                sync_q  <= '0;
                dcnt_q  <= '0;
                level_q <= 1'b0;
                pulse_q <= 1'b0;
                cnt_q   <= '0;
            end else begin
                sync_q  <= sync_d;
                dcnt_q  <= dcnt_d;
                level_q <= level_d;
                pulse_q <= pulse_d;
                cnt_q   <= cnt_d;
            end
        end

        assign level[i]                 = level_q;
        assign pulse[i]                 = pulse_q;
        assign cnt[i*CNT_W +: CNT_W]    = cnt_q;
    end

    assign any_edge = |pulse;

endmodule

// File: tb/tb_multi_edge_detector.sv
// Directed bench for multi_edge_detector: a default instance (CNT_W=8) and a CNT_W=4 instance
// for the saturation test.
module tb_multi_edge_detector;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [3:0]  din;
    logic [7:0]  mode;
    logic [3:0]  cnt_clr;
    logic [3:0]  level;
    logic [3:0]  pulse;
    logic [31:0] cnt;
    logic        any_edge;

    logic [3:0]  din4;
    logic [7:0]  mode4;
    logic [3:0]  cnt_clr4;
    logic [3:0]  level4;
    logic [3:0]  pulse4;
    logic [15:0] cnt4;
    logic        any_edge4;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    multi_edge_detector #(.CH(4), .SYNC(2), .DEB(3), .CNT_W(8)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .din      (din),
        .mode     (mode),
        .cnt_clr  (cnt_clr),
        .level    (level),
        .pulse    (pulse),
        .cnt      (cnt),
        .any_edge (any_edge)
    );

    multi_edge_detector #(.CH(4), .SYNC(2), .DEB(3), .CNT_W(4)) u_dut4 (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .din      (din4),
        .mode     (mode4),
        .cnt_clr  (cnt_clr4),
        .level    (level4),
        .pulse    (pulse4),
        .cnt      (cnt4),
        .any_edge (any_edge4)
    );

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp)
        else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic seen;
        rst      = 1'b0;
        enable   = 1'b1;
        din      = 4'b0000;
        mode     = {2'b01, 2'b11, 2'b11, 2'b01};
        cnt_clr  = 4'b0000;
        din4     = 4'b0000;
        mode4    = 8'b0000_0001;
        cnt_clr4 = 4'b0000;

        // Reset state
        #12;
        chk("rst_level", {28'd0, level}, 32'd0);
        chk("rst_pulse", {28'd0, pulse}, 32'd0);
        chk("rst_cnt", cnt, 32'd0);
        chk("rst_any", {31'd0, any_edge}, 32'd0);
        rst = 1'b1;
        step(1);

        // 1: rising edge on ch0, 5-edge latency
        din[0] = 1'b1;
        step(4);
        chk("t1_level_early", {28'd0, level}, 32'h0);
        chk("t1_pulse_early", {28'd0, pulse}, 32'h0);
        step(1);
        chk("t1_level", {28'd0, level}, 32'h1);
        chk("t1_pulse", {28'd0, pulse}, 32'h1);
        chk("t1_any", {31'd0, any_edge}, 32'd1);
        chk("t1_cnt0", {24'd0, cnt[7:0]}, 32'd1);
        step(1);
        chk("t1_pulse_off", {28'd0, pulse}, 32'h0);
        chk("t1_any_off", {31'd0, any_edge}, 32'd0);

        // 2: 2-cycle glitch on ch1 is filtered
        din[1] = 1'b1;
        step(2);
        din[1] = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step(1);
            seen = seen | pulse[1] | level[1];
        end
        chk("t2_glitch_seen", {31'd0, seen}, 32'd0);
        chk("t2_cnt1", {24'd0, cnt[15:8]}, 32'd0);

        // 3: both-edge mode on ch2, then falling-only
        din[2] = 1'b1;
        step(5);
        chk("t3_pulse_a", {28'd0, pulse}, 32'h4);
        step(5);
        din[2] = 1'b0;
        step(5);
        chk("t3_pulse_b", {28'd0, pulse}, 32'h4);
        chk("t3_level_b", {31'd0, level[2]}, 32'd0);
        step(5);
        din[2] = 1'b1;
        step(5);
        chk("t3_pulse_c", {28'd0, pulse}, 32'h4);
        chk("t3_cnt2_c", {24'd0, cnt[23:16]}, 32'd3);
        mode[5:4] = 2'b10;
        step(5);
        din[2] = 1'b0;
        step(5);
        chk("t3_fall_pulse", {28'd0, pulse}, 32'h4);
        chk("t3_cnt2_fall", {24'd0, cnt[23:16]}, 32'd4);
        step(5);
        din[2] = 1'b1;
        step(5);
        chk("t3_rise_nopulse", {28'd0, pulse}, 32'h0);
        chk("t3_level_rise", {31'd0, level[2]}, 32'd1);
        chk("t3_cnt2_hold", {24'd0, cnt[23:16]}, 32'd4);

        // 4: edge lost while enable=0, no retroactive pulse
        enable = 1'b0;
        din[3] = 1'b1;
        step(5);
        chk("t4_level3", {31'd0, level[3]}, 32'd1);
        chk("t4_pulse", {28'd0, pulse}, 32'h0);
        enable = 1'b1;
        step(1);
        chk("t4_pulse_reen", {28'd0, pulse}, 32'h0);
        step(3);
        chk("t4_cnt3", {24'd0, cnt[31:24]}, 32'd0);

        // mode=00 on ch1: level tracks, no pulse, counter holds
        mode[3:2] = 2'b00;
        din[1] = 1'b1;
        step(5);
        chk("off_level1", {31'd0, level[1]}, 32'd1);
        chk("off_pulse", {28'd0, pulse}, 32'h0);
        chk("off_cnt1", {24'd0, cnt[15:8]}, 32'd0);

        // Simultaneous falls on all channels
        mode = 8'hFF;
        din  = 4'b0000;
        step(5);
        chk("sim_pulse", {28'd0, pulse}, 32'hF);
        chk("sim_any", {31'd0, any_edge}, 32'd1);
        chk("sim_level", {28'd0, level}, 32'h0);
        chk("sim_cnt", cnt, 32'h0105_0102);

        // Plain counter clear on ch2
        cnt_clr = 4'b0100;
        step(1);
        cnt_clr = 4'b0000;
        chk("clr_cnt", cnt, 32'h0100_0102);

        // 5: CNT_W=4 saturation, clear wins over increment
        for (int k = 0; k < 17; k++) begin
            din4[0] = 1'b1;
            step(5);
            if (k == 16) chk("t5_pulse17", {28'd0, pulse4}, 32'h1);
            din4[0] = 1'b0;
            step(5);
        end
        chk("t5_sat", {16'd0, cnt4}, 32'h000F);
        din4[0] = 1'b1;
        step(4);
        cnt_clr4 = 4'b0001;
        step(1);
        cnt_clr4 = 4'b0000;
        chk("t5_clr_pulse", {28'd0, pulse4}, 32'h1);
        chk("t5_clr_cnt", {16'd0, cnt4}, 32'h0000);
        din4[0] = 1'b0;
        step(5);
        din4[0] = 1'b1;
        step(5);
        chk("t5_after_clr", {16'd0, cnt4}, 32'h0001);

        // 6: reset mid-debounce, then a rise from the held input after release
        mode = 8'hFD;
        din[0] = 1'b1;
        step(3);
        #2 rst = 1'b0;
        #1;
        chk("t6_rst_level", {28'd0, level}, 32'h0);
        chk("t6_rst_cnt", cnt, 32'd0);
        chk("t6_rst_cnt4", {16'd0, cnt4}, 32'd0);
        step(1);
        chk("t6_rst_pulse", {28'd0, pulse}, 32'h0);
        rst = 1'b1;
        step(4);
        chk("t6_level_early", {28'd0, level}, 32'h0);
        step(1);
        chk("t6_pulse", {28'd0, pulse}, 32'h1);
        chk("t6_level", {28'd0, level}, 32'h1);
        chk("t6_cnt", cnt, 32'h0000_0001);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
